// File: rtl/data_memory_bank.sv
// data_memory_bank: single-port sync data RAM, byte enables, rvalid, clear FSM.
// Ports: clk rst_n en wen be addr data_in clr -> data_out rvalid busy; opt DMEM_WRITE_THROUGH_EN.
module data_memory_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    wen,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    clr,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rvalid,
  output logic                    busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH/8;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    rvalid_q, rvalid_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    we;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [DATA_WIDTH-1:0]   merged;

  assign rdata = mem_q[addr];

  // Old word with the enabled bytes replaced by data_in.
  always_comb begin
    merged = rdata;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) merged[8*i +: 8] = data_in[8*i +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    rvalid_d = 1'b0;
    we       = 1'b0;
    waddr    = addr;
    wdata    = merged;
    unique case (state_q)
      CLEAR: begin
        we     = 1'b1;
        waddr  = cnt_q;
        wdata  = '0;
        dout_d = '0;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == ADDR_WIDTH'(DEPTH-1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
          dout_d  = '0;
        end else if (en && wen) begin
          we = 1'b1;
`ifdef DMEM_WRITE_THROUGH_EN
          dout_d   = merged;
          rvalid_d = 1'b1;
`endif
        end else if (en) begin
          dout_d   = rdata;
          rvalid_d = 1'b1;
        end else begin
          dout_d = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= CLEAR;
      cnt_q    <= '0;
      dout_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Array has no reset; the CLEAR state zeroes it.
  always_ff @(posedge clk) begin
    if (rst_n && we) mem_q[waddr] <= wdata;
  end

  assign data_out = dout_q;
  assign rvalid   = rvalid_q;
  assign busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_data_memory_bank.sv
// tb_data_memory_bank: table vectors, directed clears and random model check.
// Second instance covers DATA_WIDTH=64, ADDR_WIDTH=4.
module tb_data_memory_bank;

`ifdef DMEM_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, en, wen, clr;
  logic [3:0]  be;
  logic [7:0]  addr;
  logic [31:0] data_in, data_out;
  logic        rvalid, busy;

  logic        r64, en64, wen64, clr64;
  logic [7:0]  be64;
  logic [3:0]  a64;
  logic [63:0] d64, do64;
  logic        rv64, busy64;

  always #5 clk = ~clk;

  data_memory_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wen(wen), .be(be),
    .addr(addr), .data_in(data_in), .clr(clr),
    .data_out(data_out), .rvalid(rvalid), .busy(busy)
  );

  data_memory_bank #(.DATA_WIDTH(64), .ADDR_WIDTH(4)) u64 (
    .clk(clk), .rst_n(r64), .en(en64), .wen(wen64), .be(be64),
    .addr(a64), .data_in(d64), .clr(clr64),
    .data_out(do64), .rvalid(rv64), .busy(busy64)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mm [256];
  int          busy_left;
  logic [31:0] e_do;
  bit          e_rv;

  task automatic model(input bit r, input bit e, input bit w,
                       input logic [3:0] b, input logic [7:0] a,
                       input logic [31:0] d, input bit c);
    if (!r || (busy_left == 0 && c)) begin
      busy_left = 256;
      for (int i = 0; i < 256; i++) mm[i] = '0;
      e_do = '0;
      e_rv = 1'b0;
    end else if (busy_left > 0) begin
      busy_left--;
      e_do = '0;
      e_rv = 1'b0;
    end else if (e && w) begin
      for (int i = 0; i < 4; i++)
        if (b[i]) mm[a][8*i +: 8] = d[8*i +: 8];
      if (WT) begin
        e_do = mm[a];
        e_rv = 1'b1;
      end else begin
        e_rv = 1'b0;
      end
    end else if (e) begin
      e_do = mm[a];
      e_rv = 1'b1;
    end else begin
      e_do = '0;
      e_rv = 1'b0;
    end
  endtask

  task automatic step(input bit r, input bit e, input bit w,
                      input logic [3:0] b, input logic [7:0] a,
                      input logic [31:0] d, input bit c);
    rst_n = r; en = e; wen = w; be = b;
    addr = a; data_in = d; clr = c;
    @(posedge clk);
    model(r, e, w, b, a, d, c);
    #1;
    vectors++;
    if (data_out !== e_do || rvalid !== e_rv ||
        busy !== (busy_left > 0)) begin
      miscompares++;
      $display("FAIL model a=%h: do=%h rv=%b busy=%b want do=%h rv=%b busy=%b",
               a, data_out, rvalid, busy, e_do, e_rv, busy_left > 0);
    end
  endtask

  task automatic rnd_step(input bit allow_clr);
    bit c;
    c = allow_clr && ($urandom_range(0, 199) == 0);
    step(1'b1, 1'(($urandom_range(0, 3)) != 0), 1'($urandom_range(0, 1)),
         4'($urandom), 8'($urandom_range(0, 15)), $urandom, c);
  endtask

  task automatic wait_busy(input int exp_len, input string nm);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      rnd_step(1'b1);
      n++;
    end
    vectors++;
    if (n != exp_len) begin
      miscompares++;
      $display("FAIL %s busy_len got=%0d want=%0d", nm, n, exp_len);
    end
  endtask

  task automatic expect_rd(input logic [7:0] a, input logic [31:0] x,
                           input string nm);
    step(1'b1, 1'b1, 1'b0, 4'h0, a, 32'h0, 1'b0);
    vectors++;
    if (data_out !== x || rvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s do=%h rv=%b want do=%h rv=1", nm, data_out, rvalid, x);
    end
  endtask

  typedef struct {
    bit          en, wen;
    logic [3:0]  be;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] x_do;
    bit          x_rv;
  } vec_t;

  vec_t tbl [11];

  initial begin
    busy_left = 256;
    e_do = '0; e_rv = 1'b0;
    r64 = 1'b0; en64 = 1'b0; wen64 = 1'b0; clr64 = 1'b0;
    be64 = '0; a64 = '0; d64 = '0;

    tbl[0]  = '{1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 32'h0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 4'hF, 8'h10, 32'hAABBCCDD,
                WT ? 32'hAABBCCDD : 32'h0, WT};
    tbl[2]  = '{1'b1, 1'b1, 4'h5, 8'h10, 32'h11223344,
                WT ? 32'hAA22CC44 : 32'h0, WT};
    tbl[3]  = '{1'b1, 1'b1, 4'h0, 8'h10, 32'hFFFFFFFF,
                WT ? 32'hAA22CC44 : 32'h0, WT};
    tbl[4]  = '{1'b1, 1'b1, 4'hF, 8'h11, 32'h55667788,
                WT ? 32'h55667788 : 32'h0, WT};
    tbl[5]  = '{1'b1, 1'b0, 4'h0, 8'h10, 32'h0, 32'hAA22CC44, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 4'h0, 8'h11, 32'h0, 32'h55667788, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 4'h0, 8'h10, 32'h0, 32'hAA22CC44, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 4'h0, 8'h10, 32'h0, 32'h0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 4'h8, 8'h10, 32'h99000000,
                WT ? 32'h9922CC44 : 32'h0, WT};
    tbl[10] = '{1'b1, 1'b0, 4'h0, 8'h10, 32'h0, 32'h9922CC44, 1'b1};

    step(1'b0, 1'b1, 1'b1, 4'hF, 8'h00, 32'h1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'hF, 8'h00, 32'h1, 1'b0);
    wait_busy(256, "reset_clear");
    expect_rd(8'h00, 32'h0, "rd_00");
    expect_rd(8'h7F, 32'h0, "rd_7f");
    expect_rd(8'hFF, 32'h0, "rd_ff");

    for (int i = 0; i < 11; i++) begin
      step(1'b1, tbl[i].en, tbl[i].wen, tbl[i].be, tbl[i].a,
           tbl[i].d, 1'b0);
      vectors++;
      if (data_out !== tbl[i].x_do || rvalid !== tbl[i].x_rv) begin
        miscompares++;
        $display("FAIL tbl[%0d] do=%h rv=%b want do=%h rv=%b", i,
                 data_out, rvalid, tbl[i].x_do, tbl[i].x_rv);
      end
    end

    step(1'b1, 1'b1, 1'b1, 4'hF, 8'h05, 32'hDEADBEEF, 1'b0);
    expect_rd(8'h05, 32'hDEADBEEF, "fill_05");
    step(1'b1, 1'b1, 1'b1, 4'hF, 8'h06, 32'h12345678, 1'b1);
    wait_busy(256, "clr_req");
    expect_rd(8'h05, 32'h0, "clr_05");
    expect_rd(8'h06, 32'h0, "clr_06");

    step(1'b1, 1'b1, 1'b1, 4'hF, 8'h20, 32'hCAFEF00D, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1);
    for (int i = 0; i < 99; i++) rnd_step(1'b1);
    step(1'b0, 1'b1, 1'b1, 4'hF, 8'h21, 32'h77777777, 1'b0);
    wait_busy(256, "rst_mid_clear");
    for (int i = 0; i < 256; i++)
      step(1'b1, 1'b1, 1'b0, 4'h0, 8'(i), 32'h0, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      rnd_step(1'b1);
      if (busy_left > 0) wait_busy(busy_left, "rnd_clr");
    end

    r64 = 1'b0;
    @(posedge clk); #1;
    r64 = 1'b1;
    begin
      int n;
      n = 0;
      while (busy64 === 1'b1 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      vectors++;
      if (n != 16) begin
        miscompares++;
        $display("FAIL w64_busy_len got=%0d want=16", n);
      end
    end
    en64 = 1'b1; wen64 = 1'b1; be64 = 8'hF0;
    a64 = 4'h3; d64 = 64'h0123456789ABCDEF;
    @(posedge clk); #1;
    vectors++;
    if (rv64 !== WT ||
        do64 !== (WT ? 64'h0123456700000000 : 64'h0)) begin
      miscompares++;
      $display("FAIL w64_write do=%h rv=%b want rv=%b", do64, rv64, WT);
    end
    wen64 = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (rv64 !== 1'b1 || do64 !== 64'h0123456700000000) begin
      miscompares++;
      $display("FAIL w64_read do=%h rv=%b want do=0123456700000000 rv=1",
               do64, rv64);
    end
    en64 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_memory_bank.md
Name: data_memory_bank

Overview:
- Parametrised successor to the processor's fixed 256x32 data memory: single-port, synchronous, configurable width and depth.
- Adds per-byte write enables, a registered read-valid strobe, and a hardware clear sequencer that zeroes the array after reset or on request.
- Sits between the load/store stage and the data bus; the processor stalls while busy is high.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, word-address width in bits.
- DEPTH, 2**ADDR_WIDTH, number of words; derived, never overridden.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  chip enable / access request.
- wen  input  1  write enable; 1 = write, 0 = read; qualified by en.
- be  input  DATA_WIDTH/8  byte write enables; bit i covers data_in[8i+7:8i].
- addr  input  ADDR_WIDTH  word address.
- data_in  input  DATA_WIDTH  write data.
- clr  input  1  one-cycle request to zero the whole array.
- data_out  output  DATA_WIDTH  registered read data.
- rvalid  output  1  high for one cycle when data_out holds fresh read data.
- busy  output  1  high while the clear sequencer runs; all accesses are ignored.

Behaviour:
- Reset: rst_n sampled low at a clock edge gives data_out=0, rvalid=0, busy=1, state=CLEAR, clear counter cnt=0.
- The array itself is not reset directly; the CLEAR state zeroes it.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Each cycle writes 0 to mem[cnt], then cnt increments.
  - The cycle that writes DEPTH-1 moves to IDLE on the next edge.
  - CLEAR lasts exactly DEPTH cycles; busy=1 throughout and drops to 0 on entry to IDLE.
  - en, wen, be and clr are ignored; data_out=0, rvalid=0.
- IDLE, clr=1:
  - Next state is CLEAR with cnt=0, busy=1 next cycle.
  - Any same-cycle access is dropped: no write, rvalid=0.
- IDLE, en=1, wen=1 (write):
  - For each i with be[i]=1, mem[addr] byte i takes data_in byte i; other bytes are unchanged.
  - be all zero means no change.
  - data_out holds its previous value; rvalid=0.
- IDLE, en=1, wen=0 (read):
  - data_out takes mem[addr] at the edge, i.e. one-cycle latency.
  - rvalid=1 in the following cycle.
  - Back-to-back reads give back-to-back rvalid pulses.
- IDLE, en=0: data_out takes 0, rvalid=0.
- Read of an address written in the previous cycle returns the new merged word.
- Reset asserted mid-CLEAR or mid-access restarts CLEAR from cnt=0; a write on the edge where rst_n is low is not performed.
- Every addr value is legal, since DEPTH = 2**ADDR_WIDTH; the counter wraps only via the FSM exit.

Optional Feature:
- Macro DMEM_WRITE_THROUGH_EN.
- Defined: a write cycle also loads data_out with the merged post-write word (old bytes where be=0, new bytes where be=1) and pulses rvalid=1 the next cycle, the same as a read of that address.
- Undefined: write cycles leave data_out unchanged and keep rvalid=0, as specified above.

Test Plan:
- Reset and clear: rst_n low 2 cycles, then high → busy=1 for exactly 256 cycles then 0; read of addr 0x00, 0x7F and 0xFF each returns 0x00000000 with rvalid=1 one cycle after the request.
- Byte merge:
  - Write 0xAABBCCDD to addr 0x10 with be=4'b1111, then write 0x11223344 with be=4'b0101 → read of 0x10 returns 0xAA22CC44.
  - Write with be=0 → word unchanged.
- Read latency and disable:
  - Reads of 0x10, 0x11, 0x10 on consecutive cycles → three consecutive rvalid pulses with the matching data, each one cycle late.
  - en=0 → data_out=0, rvalid=0 the next cycle.
- Clear request:
  - Fill 0x05 with 0xDEADBEEF, pulse clr together with a write of 0x12345678 to 0x06 → write dropped, busy=1 for 256 cycles, then both 0x05 and 0x06 read 0.
  - Requests issued during busy are ignored, with rvalid=0.
- Reset mid-clear: assert rst_n low at clear cycle 100 → busy stays high for a full 256 cycles after release; all words read 0.
- Parameter and feature sweep:
  - DATA_WIDTH=64, ADDR_WIDTH=4: write 0x0123456789ABCDEF with be=8'hF0 to 0x3 → reads 0x0123456700000000; busy lasts 16 cycles after reset.
  - With DMEM_WRITE_THROUGH_EN defined: the same write gives rvalid=1 and data_out=0x0123456700000000 the next cycle.
